// File: rtl/data_mem_io.sv
// data_mem_io: dual-port data RAM plus memory-mapped player/die/timer I/O for the game CPU.
// Define DMEM_POS_SYNC_EN to put 2-flop synchronizers on pos_in and time_up.
module data_mem_io #(
  parameter int          NPLAYERS  = 2,
  parameter int          POS_W     = 4,
  parameter int          RAM_DEPTH = 8,
  parameter logic [31:0] RAM_BASE  = 32'h0000_6000,
  parameter logic [31:0] IO_BASE   = 32'h0000_7000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               addr_A,
  input  logic [31:0]               addr_B,
  input  logic [31:0]               WD,
  input  logic                      WE,
  input  logic [NPLAYERS*POS_W-1:0] pos_in,
  input  logic                      time_up,
  output logic [31:0]               RD,
  output logic [31:0]               DataVideo,
  output logic [NPLAYERS*POS_W-1:0] pos_out,
  output logic [2:0]                die
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PW = NPLAYERS * POS_W;

  logic [31:0]         mem [RAM_DEPTH];
  logic [29:0]         ram_word_a, ram_word_b, io_word_a;
  logic                ram_hit_a, ram_hit_b;
  logic [AW-1:0]       ram_idx_a, ram_idx_b;
  logic [PW-1:0]       pos_cap;
  logic                tu_cap, tu_r, time_flag, time_clr;
  logic [NPLAYERS-1:0] chg, chg_set, chg_clr;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic [31:0]         rd_next;
  logic                unused;

  // Word indices relative to each window; addresses below a base wrap to huge values and miss.
  assign ram_word_a = addr_A[31:2] - RAM_BASE[31:2];
  assign ram_word_b = addr_B[31:2] - RAM_BASE[31:2];
  assign io_word_a  = addr_A[31:2] - IO_BASE[31:2];
  assign ram_hit_a  = (ram_word_a < 30'(RAM_DEPTH));
  assign ram_hit_b  = (ram_word_b < 30'(RAM_DEPTH));
  assign ram_idx_a  = ram_word_a[AW-1:0];
  assign ram_idx_b  = ram_word_b[AW-1:0];
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign unused     = ^{addr_A[1:0], addr_B[1:0]};

`ifdef DMEM_POS_SYNC_EN
  logic [PW-1:0] pos_meta;
  logic          tu_meta;

  // First synchronizer flop; pos_out and tu_r act as the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_meta <= '0;
      tu_meta  <= 1'b0;
    end else begin
      pos_meta <= pos_in;
      tu_meta  <= time_up;
    end
  end

  assign pos_cap = pos_meta;
  assign tu_cap  = tu_meta;
`else
  assign pos_cap = pos_in;
  assign tu_cap  = time_up;
`endif

  // Per-player change detect between the value being captured and the held one.
  always_comb begin
    chg_set = '0;
    for (int k = 0; k < NPLAYERS; k++) begin
      chg_set[k] = (pos_cap[k*POS_W +: POS_W] != pos_out[k*POS_W +: POS_W]);
    end
  end

  // Write-1-to-clear strobes for the sticky I/O flags.
  always_comb begin
    chg_clr  = '0;
    time_clr = 1'b0;
    if (WE && !ram_hit_a) begin
      if (io_word_a == 30'd16) begin
        chg_clr = WD[NPLAYERS-1:0];
      end else if (io_word_a == 30'd18) begin
        time_clr = WD[0];
      end else begin
        chg_clr  = '0;
        time_clr = 1'b0;
      end
    end else begin
      chg_clr  = '0;
      time_clr = 1'b0;
    end
  end

  // CPU read mux over RAM and the I/O registers; unmapped addresses read zero.
  always_comb begin
    rd_next = 32'h0;
    if (ram_hit_a) begin
      rd_next = mem[ram_idx_a];
    end else if (io_word_a < 30'(NPLAYERS)) begin
      for (int k = 0; k < NPLAYERS; k++) begin
        if (io_word_a == 30'(k)) begin
          rd_next[POS_W-1:0] = pos_out[k*POS_W +: POS_W];
        end else begin
          rd_next = rd_next;
        end
      end
    end else if (io_word_a == 30'd16) begin
      rd_next[NPLAYERS-1:0] = chg;
    end else if (io_word_a == 30'd17) begin
      rd_next[2:0] = die;
    end else if (io_word_a == 30'd18) begin
      rd_next[0] = time_flag;
    end else begin
      rd_next = 32'h0;
    end
  end

  // RAM write port; an edge taken while reset is low writes nothing.
  always_ff @(posedge clk) begin
    if (reset && WE && ram_hit_a) begin
      mem[ram_idx_a] <= WD;
    end
  end

  // Captured positions, sticky flags (set beats clear), die LFSR and registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_out   <= '0;
      chg       <= '0;
      tu_r      <= 1'b0;
      time_flag <= 1'b0;
      lfsr      <= LFSR_SEED;
      die       <= 3'd1;
      RD        <= 32'h0;
      DataVideo <= 32'h0;
    end else begin
      pos_out   <= pos_cap;
      chg       <= (chg & ~chg_clr) | chg_set;
      tu_r      <= tu_cap;
      time_flag <= (time_flag & ~time_clr) | (tu_cap & ~tu_r);
      lfsr      <= {lfsr_fb, lfsr[15:1]};
      if (lfsr[2:0] != 3'd0 && lfsr[2:0] != 3'd7) begin
        die <= lfsr[2:0];
      end else begin
        die <= die;
      end
      RD        <= rd_next;
      DataVideo <= ram_hit_b ? mem[ram_idx_b] : 32'h0;
    end
  end
endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: randomized scoreboard bench for data_mem_io against a cycle-level
// behavioural model of the address map, sticky flags, die and RAM.
module tb_data_mem_io;
  localparam int          NP        = 2;
  localparam int          POS_W     = 4;
  localparam int          RAM_DEPTH = 8;
  localparam logic [31:0] RB        = 32'h0000_6000;
  localparam logic [31:0] IB        = 32'h0000_7000;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          PW        = NP * POS_W;
`ifdef DMEM_POS_SYNC_EN
  localparam int          L         = 2;
`else
  localparam int          L         = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   addr_A, addr_B, WD;
  logic          WE;
  logic [PW-1:0] pos_in;
  logic          time_up;
  logic [31:0]   RD, DataVideo;
  logic [PW-1:0] pos_out;
  logic [2:0]    die;

  data_mem_io #(
    .NPLAYERS(NP), .POS_W(POS_W), .RAM_DEPTH(RAM_DEPTH),
    .RAM_BASE(RB), .IO_BASE(IB), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .addr_A(addr_A), .addr_B(addr_B), .WD(WD), .WE(WE),
    .pos_in(pos_in), .time_up(time_up), .RD(RD), .DataVideo(DataVideo),
    .pos_out(pos_out), .die(die)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rd;
    bit            rd_chk;
    logic [31:0]   dv;
    bit            dv_chk;
    logic [PW-1:0] pos;
    logic [2:0]    die;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   seen [8];

  // Reference model state
  logic [31:0]   m_ram [RAM_DEPTH];
  bit            m_ok  [RAM_DEPTH];
  logic [PW-1:0] m_pos;
  logic [NP-1:0] m_chg;
  bit            m_tu, m_time;
  logic [15:0]   m_lfsr;
  logic [2:0]    m_die;
  logic [PW-1:0] pos_dq[$];
  bit            tu_dq[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = '0;
    m_chg  = '0;
    m_tu   = 1'b0;
    m_time = 1'b0;
    m_lfsr = SEED;
    m_die  = 3'd1;
    pos_dq = {};
    tu_dq  = {};
    for (int k = 0; k < L - 1; k++) begin
      pos_dq.push_back('0);
      tu_dq.push_back(1'b0);
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit ok);
    logic [31:0] w, i;
    w  = (a - RB) >> 2;
    i  = (a - IB) >> 2;
    v  = 32'h0;
    ok = 1'b1;
    if (w < RAM_DEPTH) begin
      v  = m_ram[w];
      ok = m_ok[w];
    end else if (i < NP) v = 32'(m_pos[i*POS_W +: POS_W]);
    else if (i == 16) v = 32'(m_chg);
    else if (i == 17) v = 32'(m_die);
    else if (i == 18) v = 32'(m_time);
  endtask

  // Called at a negedge: drive one cycle, predict its outcome, advance to the next negedge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic we, input logic [PW-1:0] p, input logic t);
    exp_t          e;
    logic [31:0]   w, i;
    logic [PW-1:0] cap;
    logic [NP-1:0] set, clr;
    bit            tn, tclr;
    logic [15:0]   fb;
    addr_A = a; addr_B = b; WD = d; WE = we; pos_in = p; time_up = t;
    model_read(a, e.rd, e.rd_chk);
    w = (b - RB) >> 2;
    if (w < RAM_DEPTH) begin
      e.dv = m_ram[w]; e.dv_chk = m_ok[w];
    end else begin
      e.dv = 32'h0; e.dv_chk = 1'b1;
    end
    pos_dq.push_back(p);
    cap = pos_dq.pop_front();
    tu_dq.push_back(t);
    tn = tu_dq.pop_front();
    set = '0;
    for (int k = 0; k < NP; k++)
      if (cap[k*POS_W +: POS_W] != m_pos[k*POS_W +: POS_W]) set[k] = 1'b1;
    clr  = '0;
    tclr = 1'b0;
    w = (a - RB) >> 2;
    i = (a - IB) >> 2;
    if (we) begin
      if (w < RAM_DEPTH) begin
        m_ram[w] = d; m_ok[w] = 1'b1;
      end else if (i == 16) clr = d[NP-1:0];
      else if (i == 18) tclr = d[0];
    end
    m_chg  = (m_chg & ~clr) | set;
    m_time = (m_time && !tclr) || (tn && !m_tu);
    m_tu   = tn;
    m_pos  = cap;
    if (m_lfsr % 8 >= 1 && m_lfsr % 8 <= 6) m_die = 3'(m_lfsr % 8);
    fb     = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1;
    m_lfsr = (m_lfsr >> 1) | (fb << 15);
    e.pos  = m_pos;
    e.die  = m_die;
    sb.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = RB + 32'(4 * $urandom_range(0, RAM_DEPTH - 1));
      4:          a = IB + 32'(4 * $urandom_range(0, NP - 1));
      5:          a = IB + 32'h40;
      6:          a = IB + 32'h44;
      7:          a = IB + 32'h48;
      8:          a = ($urandom_range(0, 1) == 0) ? 32'h0000_5000 : IB + 32'h4C;
      default:    a = RB + 32'(4 * RAM_DEPTH);
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  // Monitor: one expected entry per modeled clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.rd_chk) check32("RD", RD, e.rd);
        if (e.dv_chk) check32("DataVideo", DataVideo, e.dv);
        check32("pos_out", 32'(pos_out), 32'(e.pos));
        check32("die", 32'(die), 32'(e.die));
        seen[die] = 1'b1;
      end
    end
  end

  initial begin
    logic [PW-1:0] pv, pr;
    logic          tr;
    bit            cov;
    reset = 1'b0; addr_A = '0; addr_B = '0; WD = '0; WE = 1'b0; pos_in = '0; time_up = 1'b0;
    for (int k = 0; k < RAM_DEPTH; k++) m_ok[k] = 1'b0;
    for (int k = 0; k < 8; k++) seen[k] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check32("reset RD", RD, 32'h0);
    check32("reset DataVideo", DataVideo, 32'h0);
    check32("reset pos_out", 32'(pos_out), 32'h0);
    check32("reset die", 32'(die), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    pv = '0;
    step(IB + 32'h44, RB, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b0);
    step(RB + 32'h8, RB + 32'h8, 32'h1111_1111, 1'b1, pv, 1'b0);
    step(RB + 32'h8, RB + 32'h8, 32'hDEAD_BEEF, 1'b1, pv, 1'b0);
    step(RB + 32'h8, RB + 32'h8, 32'h0, 1'b0, pv, 1'b0);

    pv[POS_W +: POS_W] = POS_W'(3);
    repeat (3) step(IB + 32'h4, RB, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h40, RB, 32'hFFFF_FFFF, 1'b1, pv, 1'b0);
    step(IB + 32'h40, RB, 32'h0, 1'b0, pv, 1'b0);
    pv[POS_W +: POS_W] = POS_W'(9);
    repeat (3) step(IB + 32'h4, RB, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h40, RB, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h40, RB, 32'h2, 1'b1, pv, 1'b0);
    step(IB + 32'h40, RB, 32'h0, 1'b0, pv, 1'b0);

    repeat (5) step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b1);
    repeat (3) step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b0);
    repeat (4) step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b1);
    step(IB + 32'h48, RB, 32'h1, 1'b1, pv, 1'b1);
    repeat (3) step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b1);
    for (int j = 0; j < 4; j++) begin
      repeat (3) step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b0);
      for (int s = 0; s < 5; s++) step(IB + 32'h48, RB, 32'h1, (s == j), pv, 1'b1);
      step(IB + 32'h48, RB, 32'h0, 1'b0, pv, 1'b1);
    end

    step(32'h0000_5000, RB + 32'h100, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h60, RB, 32'h0, 1'b0, pv, 1'b0);
    step(IB, RB, 32'h0000_00FF, 1'b1, pv, 1'b0);
    step(IB, RB, 32'h0, 1'b0, pv, 1'b0);

    pr = pv;
    tr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 4) == 0)
        for (int k = 0; k < NP; k++) pr[k*POS_W +: POS_W] = POS_W'($urandom);
      if ($urandom_range(0, 3) == 0) tr = ~tr;
      step(rand_addr(),
           ($urandom_range(0, 7) == 0) ? RB - 32'h4 : RB + 32'(4 * $urandom_range(0, RAM_DEPTH - 1)),
           $urandom, ($urandom_range(0, 3) == 0), pr, tr);
    end

    addr_A = RB + 32'h8; addr_B = RB + 32'h8; WD = 32'hBAD0_BAD0; WE = 1'b1;
    reset = 1'b0;
    #1;
    check32("midreset RD", RD, 32'h0);
    check32("midreset DataVideo", DataVideo, 32'h0);
    check32("midreset pos_out", 32'(pos_out), 32'h0);
    check32("midreset die", 32'(die), 32'h1);
    repeat (2) @(negedge clk);
    WE = 1'b0;
    reset = 1'b1;
    model_reset();
    step(RB + 32'h8, RB + 32'h8, 32'h0, 1'b0, pv, 1'b0);
    step(IB + 32'h44, RB + 32'h8, 32'h0, 1'b0, pv, 1'b0);

    cov = seen[0] || seen[7];
    for (int k = 1; k <= 6; k++) if (!seen[k]) cov = 1'b1;
    check32("die coverage", 32'(cov), 32'h0);
    check32("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_io.md
# data_mem_io

Parametrised data memory and memory-mapped I/O slave for the game CPU. It provides a true-dual-port word RAM, where port A is CPU read/write and port B is the read-only VGA fetch. It also provides N player-position input registers with sticky change flags, a 1..6 LFSR die, and a sticky time-up flag. Every CPU read returns its data after exactly one cycle, whether the address decodes to RAM or to I/O.

## Interface
- NPLAYERS, 2: number of player position inputs (1..16)
- POS_W, 4: width of each position field (1..32)
- RAM_DEPTH, 8: RAM words (power of two, 2..1024)
- RAM_BASE, 32'h0000_6000: byte base of RAM window
- IO_BASE, 32'h0000_7000: byte base of I/O window
- LFSR_SEED, 16'hACE1: LFSR reset value (non-zero)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state
- addr_A  in  32  CPU byte address; bits [1:0] ignored
- addr_B  in  32  VGA byte address; bits [1:0] ignored; RAM window only
- WD  in  32  CPU write data
- WE  in  1  CPU write strobe, sampled at clk edge
- pos_in  in  NPLAYERS*POS_W  raw player positions, player k at [k*POS_W +: POS_W]
- time_up  in  1  timer expiry level
- RD  out  32  CPU read data, registered
- DataVideo  out  32  VGA read data, registered
- pos_out  out  NPLAYERS*POS_W  captured player positions
- die  out  3  current die value 1..6

## Operation
- Address map, word index = (addr − base) >> 2:
  - RAM_BASE + 4i, i < RAM_DEPTH: RAM word i, read/write
  - IO_BASE + 4k, k < NPLAYERS: position k, zero-extended, read-only
  - IO_BASE + 0x40, CHG: bit k = position k changed since cleared. Write 1 to a bit to clear it.
  - IO_BASE + 0x44, RAND: {29'b0, die}, read-only
  - IO_BASE + 0x48, TIME: bit0 = sticky time-up. Write 1 to clear.
  - Any other address reads 32'h0. Writes to it are ignored. Writes to read-only registers are ignored.
- Position capture: pos_out is a registered copy of pos_in. CHG[k] sets on any cycle where the newly captured value differs from the previous captured value.
- Time-up: TIME sets on a rising edge of the (registered) time_up. A level held high after clearing does not re-set the flag.
- Die: a 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle. When lfsr[2:0] is in 1..6, die loads it; otherwise die holds its value.
- RAM: port A is read-first, so a read of the word being written returns the old data. When port B reads a word that port A writes in the same cycle, port B also returns the old data. If addr_B is outside the RAM window, DataVideo returns 0.
- Simultaneous events:
  - A CHG/TIME set and a write-1-clear in the same cycle: set wins, so no event is lost.
  - Bits above NPLAYERS in CHG read 0.

## Timing
- Reset values:
  - RD, DataVideo, pos_out, CHG, TIME: 0
  - die: 1
  - lfsr: LFSR_SEED
  - RAM contents: undefined (not cleared)
- Read latency: addr_A presented before edge t gives RD valid after edge t, for all targets. addr_B behaves the same for DataVideo.
- Write: takes effect at the edge where WE=1. A read of the same RAM address at edge t+1 sees the new data.
- Position latency: pos_in to pos_out/CHG is 2 edges with the macro, 1 edge without.
- Reset asserted mid-operation: all registers clear immediately. The RAM write in flight on that edge is dropped.

## Configuration
- DMEM_POS_SYNC_EN:
  - Defined: pos_in and time_up each pass a 2-flop synchronizer before capture and edge detection. Use this for asynchronous button inputs.
  - Undefined: pos_in and time_up each pass a single register stage, for inputs that are already synchronous to clk.

## Test plan
- Reset released, read IO_BASE+0x44 → RD = 32'h1 on the next cycle. Read IO_BASE+0x48 → 0.
- Write 32'hDEADBEEF to RAM_BASE+0x8, then read it back → RD = 32'hDEADBEEF one cycle later. With addr_B = RAM_BASE+0x8, DataVideo shows the same value; a same-cycle B read during the write returns the old data.
- pos_in player1 changes 4'h3→4'h9 → pos_out updates after 2 edges (macro on), and CHG reads 32'h2. Write 32'h2 to CHG → CHG reads 0.
- time_up pulses high for 5 cycles → TIME = 1. Clearing it while time_up is still high leaves TIME at 0. Clearing in the same cycle as a new rising edge leaves TIME = 1.
- Run 1000 cycles sampling die → every value is in 1..6, all six values appear, and die is never 0 or 7.
- Read 32'h0000_5000 and IO_BASE+0x60 → RD = 0. Write to IO_BASE+0x0 → pos_out is unchanged.
